// File: rtl/siggen_core.sv
// Multi-waveform generator: a prescaled phase counter drives square, sawtooth and triangle shapes.
// A free-running counter encodes the sample as PWM. Mode and rate changes land only at a phase wrap.
module siggen_core #(
   parameter int WIDTH    = 8,
   parameter int DIV_W    = 30,
   parameter int BASE_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [7:0]       rate,
   output logic [WIDTH-1:0] wave,
   output logic             sq_out,
   output logic             pwm_out,
   output logic             wrap
);

   localparam logic [DIV_W-1:0] ZERO_DIV = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] ONE_DIV  = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] BASE_C   = DIV_W'(BASE_DIV);
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

   logic [DIV_W-1:0] pre_q, pre_d, divisor_s, div_last_s;
   logic [WIDTH-1:0] phase_q, phase_d, pwm_cnt_q, pwm_cnt_d, wave_q, wave_d;
   logic [1:0]       mode_q, mode_d;
   logic [7:0]       rate_q, rate_d;
   logic             sq_q, sq_d, pwm_q, pwm_d, wrap_q, wrap_d;
   logic             tick_s, wrap_tick_s;

   function automatic logic [WIDTH-1:0] shape_f(input logic [WIDTH-1:0] ph, input logic [1:0] md);
      logic [WIDTH-1:0] t;
      logic [WIDTH-1:0] res;
      t = {ph[WIDTH-2:0], 1'b0};
      case (md)
         2'd0:    res = ph[WIDTH-1] ? ONES_W : ZERO_W;
         2'd1:    res = ph;
         2'd2:    res = ph[WIDTH-1] ? ~t : t;
         default: res = ZERO_W;
      endcase
      return res;
   endfunction

   // Divisor is formed at full prescaler width so large rate*BASE_DIV never truncates.
   assign divisor_s   = ({{(DIV_W-8){1'b0}}, rate_q} + ONE_DIV) * BASE_C;
   assign div_last_s  = divisor_s - ONE_DIV;
   assign tick_s      = en && (pre_q == div_last_s);
   assign wrap_tick_s = tick_s && (phase_q == ONES_W);

   // Next-state logic for prescaler, phase, control latches and output samples.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + ONE_W;
      pwm_d     = (wave_q > pwm_cnt_q);
      if (en) begin
         if (tick_s) begin
            pre_d   = ZERO_DIV;
            phase_d = phase_q + ONE_W;
         end else begin
            pre_d   = pre_q + ONE_DIV;
            phase_d = phase_q;
         end
         wave_d = shape_f(phase_q, mode_q);
         sq_d   = phase_q[WIDTH-1];
         wrap_d = wrap_tick_s;
         if (wrap_tick_s) begin
            mode_d = mode;
            rate_d = rate;
         end else begin
            mode_d = mode_q;
            rate_d = rate_q;
         end
      end else begin
         // Frozen: only the PWM side keeps running; controls track inputs freely.
         pre_d   = ZERO_DIV;
         phase_d = phase_q;
         wave_d  = wave_q;
         sq_d    = sq_q;
         wrap_d  = 1'b0;
         mode_d  = mode;
         rate_d  = rate;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q     <= ZERO_DIV;
         phase_q   <= ZERO_W;
         pwm_cnt_q <= ZERO_W;
         mode_q    <= 2'd0;
         rate_q    <= 8'd0;
         wave_q    <= ZERO_W;
         sq_q      <= 1'b0;
         pwm_q     <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         phase_q   <= phase_d;
         pwm_cnt_q <= pwm_cnt_d;
         mode_q    <= mode_d;
         rate_q    <= rate_d;
         wave_q    <= wave_d;
         sq_q      <= sq_d;
         pwm_q     <= pwm_d;
         wrap_q    <= wrap_d;
      end
   end

   assign wave    = wave_q;
   assign sq_out  = sq_q;
   assign pwm_out = pwm_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_siggen_core.sv
// Directed bench for siggen_core at WIDTH=4, BASE_DIV=2: shapes, glitch-free control changes,
// enable freeze, mid-run reset and PWM duty.
module tb_siggen_core;

   localparam int WIDTH    = 4;
   localparam int DIV_W    = 12;
   localparam int BASE_DIV = 2;

   logic             clk;
   logic             rst;
   logic             en;
   logic [1:0]       mode;
   logic [7:0]       rate;
   logic [WIDTH-1:0] wave;
   logic             sq_out;
   logic             pwm_out;
   logic             wrap;

   int n_vec  = 0;
   int n_miss = 0;
   int p, md, pcnt;

   siggen_core #(.WIDTH(WIDTH), .DIV_W(DIV_W), .BASE_DIV(BASE_DIV)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .rate(rate),
      .wave(wave), .sq_out(sq_out), .pwm_out(pwm_out), .wrap(wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_wave(input int ph, input int m);
      case (m)
         0:       return (ph >= 8) ? 15 : 0;
         1:       return ph;
         2:       return (ph < 8) ? 2 * ph : 15 - (2 * ph - 16);
         default: return 0;
      endcase
   endfunction

   // Phase seen by the sample register and the mode it was shaped with, per cycle index k.
   task automatic exp_point(input int k, output int ph, output int m);
      if (k <= 127) begin
         ph = (k / 2) % 16;
         m  = (k < 64) ? 1 : 2;
      end else if (k <= 327) begin
         ph = ((k - 128) / 8) % 16;
         m  = 0;
      end else if (k <= 347) begin
         ph = 8;
         m  = 0;
      end else begin
         ph = 9 + (k - 348) / 4;
         m  = 1;
      end
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      mode = 2'd1;
      rate = 8'd0;
      step();
      step();
      check_vec("reset_wave", wave, 0);
      check_vec("reset_sq", sq_out, 0);
      check_vec("reset_pwm", pwm_out, 0);
      check_vec("reset_wrap", wrap, 0);
      rst = 1'b0;
      step();
      en = 1'b1;

      for (int k = 0; k < 372; k++) begin
         step();
         exp_point(k, p, md);
         check_vec($sformatf("wave@%0d", k), wave, exp_wave(p, md));
         check_vec($sformatf("sq@%0d", k), sq_out, (p >= 8) ? 1 : 0);
         check_vec($sformatf("wrap@%0d", k), wrap,
                   (k == 31 || k == 63 || k == 95 || k == 127 || k == 255) ? 1 : 0);
         if (k == 40) mode = 2'd2;
         if (k == 105) begin
            rate = 8'd3;
            mode = 2'd0;
         end
         if (k == 327) begin
            en   = 1'b0;
            rate = 8'd1;
            mode = 2'd1;
         end
         if (k == 347) en = 1'b1;
      end

      mode = 2'd0;
      rate = 8'd0;
      rst  = 1'b1;
      step();
      check_vec("midrst_wave", wave, 0);
      check_vec("midrst_sq", sq_out, 0);
      check_vec("midrst_pwm", pwm_out, 0);
      check_vec("midrst_wrap", wrap, 0);
      rst = 1'b0;

      for (int j = 0; j < 24; j++) begin
         step();
         p = (j / 2) % 16;
         check_vec($sformatf("rs_wave@%0d", j), wave, exp_wave(p, 0));
         check_vec($sformatf("rs_wrap@%0d", j), wrap, 0);
      end
      en   = 1'b0;
      mode = 2'd3;

      pcnt = 0;
      for (int n = 0; n < 32; n++) begin
         step();
         pcnt += int'(pwm_out);
      end
      check_vec("pwm_full_highs", pcnt, 30);
      check_vec("frozen_wave", wave, 15);

      en = 1'b1;
      step();
      step();
      pcnt = 0;
      for (int n = 0; n < 32; n++) begin
         step();
         pcnt += int'(pwm_out);
         check_vec($sformatf("off_wave@%0d", n), wave, 0);
      end
      check_vec("pwm_zero_highs", pcnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
